// File: rtl/reg_slice_pkg.sv
// Shared constants for the parametrised register slice pipeline.
// Mode encodings match the legacy slice configuration values.
package reg_slice_pkg;

  localparam int RS_BYPASS   = 0;
  localparam int RS_FORWARD  = 1;
  localparam int RS_BACKWARD = 2;
  localparam int RS_FULL     = 3;

  function automatic bit rs_mode_legal(input int mode);
    return (mode >= RS_BYPASS) && (mode <= RS_FULL);
  endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// One valid/ready register slice: forward, backward (skid) or full (main + skid).
// Bypass is handled by the pipeline top, so it never reaches this module.
module reg_slice_stage
  import reg_slice_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MODE       = RS_FULL,
  parameter int RESET_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_up,
  output logic              ready_up,
  input  logic [DATA_W-1:0] data_up,
  output logic              valid_dn,
  input  logic              ready_dn,
  output logic [DATA_W-1:0] data_dn,
  output logic              busy
);

  localparam bit RST_D = (RESET_DATA != 0);

  generate
    if (MODE == RS_FORWARD) begin : g_fwd
      logic              v;
      logic [DATA_W-1:0] d;

      assign ready_up = !v || ready_dn;
      assign valid_dn = v;
      assign data_dn  = d;
      assign busy     = v;

      always_ff @(posedge clk) begin
        if (rst)           v <= 1'b0;
        else if (ready_up) v <= valid_up;
      end

      always_ff @(posedge clk) begin
        if (RST_D && rst)              d <= '0;
        else if (ready_up && valid_up) d <= data_up;
      end

    end else if (MODE == RS_BACKWARD) begin : g_bwd
      logic              sv;
      logic [DATA_W-1:0] sd;

      // rst gates both sides so nothing passes through combinationally during reset
      assign ready_up = !sv && !rst;
      assign valid_dn = sv || (valid_up && !rst);
      assign data_dn  = sv ? sd : data_up;
      assign busy     = sv;

      always_ff @(posedge clk) begin
        if (rst)                        sv <= 1'b0;
        else if (sv)                    sv <= !ready_dn;
        else if (valid_up && !ready_dn) sv <= 1'b1;
      end

      always_ff @(posedge clk) begin
        if (RST_D && rst)                      sd <= '0;
        else if (!sv && valid_up && !ready_dn) sd <= data_up;
      end

    end else if (MODE == RS_FULL) begin : g_full
      logic              mv, sv;
      logic [DATA_W-1:0] md, sd;
      logic              main_free;

      assign main_free = !mv || ready_dn;
      assign ready_up  = !sv && !rst;
      assign valid_dn  = mv;
      assign data_dn   = md;
      assign busy      = mv || sv;

      // skid has priority: while it is full upstream is stalled, so no new beat competes
      always_ff @(posedge clk) begin
        if (rst) begin
          mv <= 1'b0;
          sv <= 1'b0;
        end else if (sv) begin
          if (main_free) begin
            mv <= 1'b1;
            sv <= 1'b0;
          end
        end else if (valid_up) begin
          if (main_free) mv <= 1'b1;
          else           sv <= 1'b1;
        end else if (ready_dn) begin
          mv <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (RST_D && rst) begin
          md <= '0;
          sd <= '0;
        end else if (sv) begin
          if (main_free) md <= sd;
        end else if (valid_up) begin
          if (main_free) md <= data_up;
          else           sd <= data_up;
        end
      end

    end else begin : g_bad_mode
      $error("reg_slice_stage: unsupported MODE %0d", MODE);
    end
  endgenerate

endmodule

// File: rtl/reg_slice_pipe.sv
// Chain of STAGES identical register slices between a stream producer and consumer.
// MODE 0 is a pure wire-through; o_idle reflects registered state only.
module reg_slice_pipe
  import reg_slice_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MODE       = RS_FULL,
  parameter int STAGES     = 1,
  parameter int RESET_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_idle
);

  generate
    if (!rs_mode_legal(MODE)) begin : g_bad_mode
      $error("reg_slice_pipe: illegal MODE %0d", MODE);
    end

    if (MODE == RS_BYPASS) begin : g_byp
      logic unused_byp;
      assign unused_byp = ^{clk, rst};
      assign o_valid    = i_valid;
      assign o_data     = i_data;
      assign o_ready    = i_ready;
      assign o_idle     = 1'b1;

    end else begin : g_chain
      if (STAGES < 1) begin : g_bad_stages
        $error("reg_slice_pipe: STAGES must be >= 1, got %0d", STAGES);
      end

      // index k is the upstream side of stage k; index STAGES is the pipe output
      logic [STAGES:0]             vld_pipe;
      logic [STAGES:0]             rdy_pipe;
      logic [STAGES:0][DATA_W-1:0] dat_pipe;
      logic [STAGES-1:0]           busy;

      assign vld_pipe[0]      = i_valid;
      assign dat_pipe[0]      = i_data;
      assign o_ready          = rdy_pipe[0];
      assign rdy_pipe[STAGES] = i_ready;
      assign o_valid          = vld_pipe[STAGES];
      assign o_data           = dat_pipe[STAGES];
      assign o_idle           = ~|busy;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        reg_slice_stage #(
          .DATA_W     (DATA_W),
          .MODE       (MODE),
          .RESET_DATA (RESET_DATA)
        ) u_stage (
          .clk      (clk),
          .rst      (rst),
          .valid_up (vld_pipe[k]),
          .ready_up (rdy_pipe[k]),
          .data_up  (dat_pipe[k]),
          .valid_dn (vld_pipe[k+1]),
          .ready_dn (rdy_pipe[k+1]),
          .data_dn  (dat_pipe[k+1]),
          .busy     (busy[k])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_slice_pipe.sv
// Directed bench for reg_slice_pipe across all four modes and several depths.
module tb_reg_slice_pipe;
  import reg_slice_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // full, 2 stages, 16b, data reset
  logic f2_iv, f2_or, f2_ov, f2_ir, f2_idle;
  logic [15:0] f2_id, f2_od;
  // full, 1 stage, 16b
  logic f1_iv, f1_or, f1_ov, f1_ir, f1_idle;
  logic [15:0] f1_id, f1_od;
  // backward, 1 stage, 16b
  logic bw_iv, bw_or, bw_ov, bw_ir, bw_idle;
  logic [15:0] bw_id, bw_od;
  // forward, 3 stages, 8b
  logic fw_iv, fw_or, fw_ov, fw_ir, fw_idle;
  logic [7:0] fw_id, fw_od;
  // bypass, 64b
  logic by_iv, by_or, by_ov, by_ir, by_idle;
  logic [63:0] by_id, by_od;

  reg_slice_pipe #(.DATA_W(16), .MODE(RS_FULL), .STAGES(2), .RESET_DATA(1)) u_f2 (
    .clk(clk), .rst(rst), .i_valid(f2_iv), .o_ready(f2_or), .i_data(f2_id),
    .o_valid(f2_ov), .i_ready(f2_ir), .o_data(f2_od), .o_idle(f2_idle));
  reg_slice_pipe #(.DATA_W(16), .MODE(RS_FULL), .STAGES(1), .RESET_DATA(0)) u_f1 (
    .clk(clk), .rst(rst), .i_valid(f1_iv), .o_ready(f1_or), .i_data(f1_id),
    .o_valid(f1_ov), .i_ready(f1_ir), .o_data(f1_od), .o_idle(f1_idle));
  reg_slice_pipe #(.DATA_W(16), .MODE(RS_BACKWARD), .STAGES(1), .RESET_DATA(1)) u_bw (
    .clk(clk), .rst(rst), .i_valid(bw_iv), .o_ready(bw_or), .i_data(bw_id),
    .o_valid(bw_ov), .i_ready(bw_ir), .o_data(bw_od), .o_idle(bw_idle));
  reg_slice_pipe #(.DATA_W(8), .MODE(RS_FORWARD), .STAGES(3), .RESET_DATA(0)) u_fw (
    .clk(clk), .rst(rst), .i_valid(fw_iv), .o_ready(fw_or), .i_data(fw_id),
    .o_valid(fw_ov), .i_ready(fw_ir), .o_data(fw_od), .o_idle(fw_idle));
  reg_slice_pipe #(.DATA_W(64), .MODE(RS_BYPASS), .STAGES(1), .RESET_DATA(0)) u_by (
    .clk(clk), .rst(rst), .i_valid(by_iv), .o_ready(by_or), .i_data(by_id),
    .o_valid(by_ov), .i_ready(by_ir), .o_data(by_od), .o_idle(by_idle));

  logic [7:0] q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_iv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int t2_id [8] = '{'hA, 'hB, 'hC, 'hC, 'hC, 'hC, 0, 0};
    int t2_ir [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int t2_or [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int t2_ov [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int t2_od [8] = '{0, 'hA, 'hA, 'hA, 'hA, 'hB, 'hC, 0};
    int n, sent, rcvd;
    logic pstall;
    logic [7:0] pd, exp_d;

    rst = 1'b1;
    {f2_iv, f2_ir, f1_iv, f1_ir, bw_iv, bw_ir, fw_iv, fw_ir, by_iv, by_ir} = '0;
    f2_id = '0; f1_id = '0; bw_id = '0; fw_id = '0; by_id = '0;

    // reset state after two sampled reset edges, rst still high
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_f2_ov",   64'(f2_ov),   64'd0);
    chk("rst_f2_idle", 64'(f2_idle), 64'd1);
    chk("rst_f2_or",   64'(f2_or),   64'd0);
    chk("rst_f2_od",   64'(f2_od),   64'd0);
    chk("rst_bw_or",   64'(bw_or),   64'd0);
    chk("rst_bw_ov",   64'(bw_ov),   64'd0);
    chk("rst_fw_ov",   64'(fw_ov),   64'd0);
    chk("rst_fw_or",   64'(fw_or),   64'd1);
    chk("rst_f1_idle", 64'(f1_idle), 64'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_f2_or", 64'(f2_or), 64'd1);
    chk("rel_bw_or", 64'(bw_or), 64'd1);

    // bypass: outputs follow inputs in the same cycle
    by_iv = 1'b1; by_ir = 1'b0; by_id = 64'hDEAD_BEEF_0123_4567; #1;
    chk("by_ov0", 64'(by_ov), 64'd1);
    chk("by_od0", by_od, 64'hDEAD_BEEF_0123_4567);
    chk("by_or0", 64'(by_or), 64'd0);
    by_iv = 1'b0; by_ir = 1'b1; by_id = 64'hFFFF_0000_A5A5_5A5A; #1;
    chk("by_ov1", 64'(by_ov), 64'd0);
    chk("by_od1", by_od, 64'hFFFF_0000_A5A5_5A5A);
    chk("by_or1", 64'(by_or), 64'd1);
    chk("by_idle", 64'(by_idle), 64'd1);

    // full x2: back-to-back stream, 2-cycle latency, one beat per cycle
    f2_ir = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      f2_iv = (c < 16);
      f2_id = 16'(c + 1);
      #1;
      chk("f2_or", 64'(f2_or), 64'd1);
      chk("f2_ov", 64'(f2_ov), 64'(c >= 2 && c <= 17));
      if (c >= 2 && c <= 17) chk("f2_od", 64'(f2_od), 64'(c - 1));
    end
    @(negedge clk); f2_iv = 1'b0; #1;
    chk("f2_idle_end", 64'(f2_idle), 64'd1);

    // full x1: stall fills main and skid, then release drains in order
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      f1_iv = t2_iv[c][0];
      f1_id = 16'(t2_id[c]);
      f1_ir = t2_ir[c][0];
      #1;
      chk("f1_or", 64'(f1_or), 64'(t2_or[c]));
      chk("f1_ov", 64'(f1_ov), 64'(t2_ov[c]));
      if (t2_ov[c] != 0) chk("f1_od", 64'(f1_od), 64'(t2_od[c]));
    end
    chk("f1_idle_end", 64'(f1_idle), 64'd1);

    // backward: i_ready toggles, input 0..7 offered continuously
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bw_ir = (c % 2 == 0);
      bw_iv = (n < 8);
      bw_id = 16'(n);
      #1;
      if (c < 15) begin
        chk("bw_ov", 64'(bw_ov), 64'd1);
        chk("bw_od", 64'(bw_od), 64'((c == 0) ? 0 : ((c % 2 == 0) ? c / 2 : (c + 1) / 2)));
        chk("bw_or", 64'(bw_or), 64'(c == 0 || c % 2 == 1));
      end else begin
        chk("bw_ov_end",   64'(bw_ov),   64'd0);
        chk("bw_idle_end", 64'(bw_idle), 64'd1);
      end
      if (bw_iv && bw_or) n++;
    end

    // forward x3: random handshakes against a scoreboard, plus stall stability
    void'($urandom(32'd1234));
    sent = 0; rcvd = 0; pstall = 1'b0; pd = '0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      @(negedge clk);
      fw_iv = (sent < 1000) && ($urandom_range(0, 3) != 0);
      fw_id = 8'(sent * 7 + 3);
      fw_ir = ($urandom_range(0, 2) != 0);
      #1;
      if (pstall) begin
        chk("fw_hold_v", 64'(fw_ov), 64'd1);
        chk("fw_hold_d", 64'(fw_od), 64'(pd));
      end
      if (fw_iv && fw_or) begin
        q.push_back(fw_id);
        sent++;
      end
      if (fw_ov && fw_ir) begin
        if (q.size() == 0) chk("fw_extra", 64'(fw_ov), 64'd0);
        else begin
          exp_d = q.pop_front();
          chk("fw_data", 64'(fw_od), 64'(exp_d));
        end
        rcvd++;
      end
      pstall = fw_ov && !fw_ir;
      pd = fw_od;
    end
    chk("fw_count", 64'(rcvd), 64'd1000);
    @(negedge clk); fw_iv = 1'b0; fw_ir = 1'b0; #1;
    chk("fw_idle_end", 64'(fw_idle), 64'd1);

    // reset with beats in flight
    f2_ir = 1'b0; bw_ir = 1'b0; fw_ir = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      f2_iv = 1'b1; f2_id = 16'h11 * 16'(c + 1);
      bw_iv = (c == 0); bw_id = 16'h77;
      fw_iv = (c == 0); fw_id = 8'h5A;
      #1;
      chk("ld_f2_or", 64'(f2_or), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    f2_iv = 1'b1; f2_id = 16'h99;
    bw_iv = 1'b1; bw_id = 16'h66;
    fw_iv = 1'b0;
    #1;
    chk("mr_f2_or", 64'(f2_or), 64'd0);
    chk("mr_bw_or", 64'(bw_or), 64'd0);
    @(negedge clk); #1;
    chk("mr_f2_ov",   64'(f2_ov),   64'd0);
    chk("mr_f2_idle", 64'(f2_idle), 64'd1);
    chk("mr_f2_od",   64'(f2_od),   64'd0);
    chk("mr_bw_ov",   64'(bw_ov),   64'd0);
    chk("mr_bw_idle", 64'(bw_idle), 64'd1);
    chk("mr_fw_ov",   64'(fw_ov),   64'd0);
    chk("mr_fw_idle", 64'(fw_idle), 64'd1);
    rst = 1'b0;
    f2_iv = 1'b0; bw_iv = 1'b0;
    f2_ir = 1'b1; bw_ir = 1'b1; fw_ir = 1'b1;
    #1;
    chk("pr_f2_or", 64'(f2_or), 64'd1);
    chk("pr_bw_or", 64'(bw_or), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("pr_f2_ov", 64'(f2_ov), 64'd0);
      chk("pr_bw_ov", 64'(bw_ov), 64'd0);
      chk("pr_fw_ov", 64'(fw_ov), 64'd0);
    end

    // fresh beat after reset still sees the 2-cycle latency
    @(negedge clk); f2_iv = 1'b1; f2_id = 16'h42; #1;
    chk("nb_f2_or", 64'(f2_or), 64'd1);
    @(negedge clk); f2_iv = 1'b0; #1;
    chk("nb_f2_ov1", 64'(f2_ov), 64'd0);
    @(negedge clk); #1;
    chk("nb_f2_ov2", 64'(f2_ov), 64'd1);
    chk("nb_f2_od",  64'(f2_od), 64'h42);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
